parq_sensor_gen: RTL and testbench

Stimulus generator that drives the two parking-meter presence sensors (`psensor`, `ssensor`) with the waveform a car produces when it crosses the sensor pair. It supports entry, exit, balked entry and an illegal simultaneous jump, with optional mechanical-contact bounce on every transition. It sits on the other side of the sensor interface from the debounced parking-meter counter: on-board self-test and bench stimulus feed its outputs straight into the counter's sensor inputs.

---
 rtl/parq_pkg.sv | 59 +++++
 rtl/parq_bounce_shaper.sv | 69 ++++++
 rtl/parq_sensor_gen.sv | 146 ++++++++++++++
 tb/tb_parq_sensor_gen.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parq_pkg.sv
// Shared definitions for the parking-meter sensor stimulus generator
// and the debounced counter that consumes its outputs.
package parq_pkg;

    typedef enum logic [1:0] {
        MODE_ENTRY   = 2'b00,
        MODE_EXIT    = 2'b01,
        MODE_BALK    = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BOUNCE,
        ST_HOLD,
        ST_DONE
    } state_e;

    localparam int P_BIT = 1;
    localparam int S_BIT = 0;

    localparam logic [1:0] SENS_OFF = 2'b00;

    // Target {psensor,ssensor} for step idx of a car passage.
    function automatic logic [1:0] step_pattern(
        input logic [1:0] mode,
        input logic [1:0] idx
    );
        logic [1:0] pat;
        pat = SENS_OFF;
        if (idx != 2'd3) begin
            unique case (mode)
                MODE_ENTRY:
                    pat = (idx == 2'd0) ? 2'b10 :
                          (idx == 2'd1) ? 2'b11 : 2'b01;
                MODE_EXIT:
                    pat = (idx == 2'd0) ? 2'b01 :
                          (idx == 2'd1) ? 2'b11 : 2'b10;
                MODE_BALK:
                    pat = (idx == 2'd1) ? 2'b11 : 2'b10;
                default:
                    pat = 2'b11;
            endcase
        end
        return pat;
    endfunction

    function automatic int cnt_width(
        input int phase,
        input int blen,
        input int pulses
    );
        int m;
        m = (phase > blen) ? phase : blen;
        m = (m > 2 * pulses) ? m : 2 * pulses;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/parq_bounce_shaper.sv
// Glitch-train generator: alternates target/prev in half-periods of
// BOUNCE_LEN cycles; wave_nxt is the drive for the following cycle.
module parq_bounce_shaper
    import parq_pkg::*;
#(
    parameter int BOUNCE_PULSES = 3,
    parameter int BOUNCE_LEN    = 2,
    parameter int CW            = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [1:0] prev,
    input  logic [1:0] target,
    output logic [1:0] wave_nxt,
    output logic       settled
);

    localparam int HL = (BOUNCE_PULSES > 0) ? 2 * BOUNCE_PULSES - 1 : 0;
    localparam logic [CW-1:0] HALF_LAST = CW'(HL);
    localparam logic [CW-1:0] LEN_LAST  = CW'(BOUNCE_LEN - 1);

    logic          active_q;
    logic          active_d;
    logic [CW-1:0] half_q;
    logic [CW-1:0] half_d;
    logic [CW-1:0] len_q;
    logic [CW-1:0] len_d;

    // High during the final glitch cycle; the next cycle is settled.
    assign settled = active_q && (half_q == HALF_LAST) &&
                     (len_q == LEN_LAST);

    always_comb begin
        active_d = active_q;
        half_d   = half_q;
        len_d    = len_q;
        if (go) begin
            active_d = 1'b1;
            half_d   = '0;
            len_d    = '0;
        end else if (active_q) begin
            if (len_q == LEN_LAST) begin
                len_d = '0;
                if (half_q == HALF_LAST)
                    active_d = 1'b0;
                else
                    half_d = half_q + CW'(1);
            end else begin
                len_d = len_q + CW'(1);
            end
        end
        // Even half-periods show the target, odd ones fall back.
        wave_nxt = half_d[0] ? prev : target;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            half_q   <= '0;
            len_q    <= '0;
        end else begin
            active_q <= active_d;
            half_q   <= half_d;
            len_q    <= len_d;
        end
    end

endmodule

// File: rtl/parq_sensor_gen.sv
// Car-passage stimulus generator for the parking-meter sensor pair:
// four-step FSM with hold counter, bounce delegated to the shaper.
module parq_sensor_gen
    import parq_pkg::*;
#(
    parameter int PHASE_CYCLES  = 32,
    parameter int BOUNCE_PULSES = 3,
    parameter int BOUNCE_LEN    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       bounce_en,
    output logic       psensor,
    output logic       ssensor,
    output logic       busy,
    output logic       done
);

    localparam int CW =
        cnt_width(PHASE_CYCLES, BOUNCE_LEN, BOUNCE_PULSES);
    localparam logic [CW-1:0] PH_LAST = CW'(PHASE_CYCLES - 1);
    localparam bit BNC_OK = (BOUNCE_PULSES > 0);

    state_e        state_q;
    state_e        state_d;
    logic [1:0]    step_q;
    logic [1:0]    step_d;
    logic [1:0]    mode_q;
    logic [1:0]    mode_d;
    logic          bnc_q;
    logic          bnc_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [1:0]    sens_q;
    logic [1:0]    sens_d;
    logic [1:0]    tgt;
    logic [1:0]    prv;
    logic [1:0]    wave_nxt;
    logic          enter;
    logic          do_bnc;
    logic          go;
    logic          settled;
    logic          busy_d;
    logic          done_d;

    parq_bounce_shaper #(
        .BOUNCE_PULSES(BOUNCE_PULSES),
        .BOUNCE_LEN   (BOUNCE_LEN),
        .CW           (CW)
    ) u_shaper (
        .clk     (clk),
        .reset   (reset),
        .go      (go),
        .prev    (prv),
        .target  (tgt),
        .wave_nxt(wave_nxt),
        .settled (settled)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        bnc_d   = bnc_q;
        enter   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    bnc_d  = bounce_en;
                    step_d = 2'd0;
                    enter  = 1'b1;
                end
            end
            ST_BOUNCE: begin
                if (settled) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == PH_LAST) begin
                    if (step_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d = step_q + 2'd1;
                        enter  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Targets follow the step being entered so the shaper and the
        // output register see the new step at the same edge.
        tgt    = step_pattern(mode_d, step_d);
        prv    = (step_d == 2'd0) ? SENS_OFF
                                  : step_pattern(mode_d, step_d - 2'd1);
        do_bnc = bnc_d && BNC_OK && (tgt != prv);
        go     = enter && do_bnc;
        if (enter) begin
            state_d = do_bnc ? ST_BOUNCE : ST_HOLD;
            cnt_d   = '0;
        end

        unique case (state_d)
            ST_BOUNCE: sens_d = wave_nxt;
            ST_HOLD:   sens_d = tgt;
            default:   sens_d = SENS_OFF;
        endcase
        busy_d = (state_d == ST_BOUNCE) || (state_d == ST_HOLD);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            step_q  <= 2'd0;
            mode_q  <= 2'd0;
            bnc_q   <= 1'b0;
            cnt_q   <= '0;
            sens_q  <= SENS_OFF;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            bnc_q   <= bnc_d;
            cnt_q   <= cnt_d;
            sens_q  <= sens_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    assign psensor = sens_q[P_BIT];
    assign ssensor = sens_q[S_BIT];

endmodule

// File: tb/tb_parq_sensor_gen.sv
// Self-checking bench: queue-based waveform model compared every cycle,
// plus literal checkpoints from the hand-worked sequences.
module tb_parq_sensor_gen;

    localparam int PH = 3;
    localparam int BP = 2;
    localparam int BL = 1;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] mode;
    logic       bounce_en;
    logic       psensor;
    logic       ssensor;
    logic       busy;
    logic       done;

    logic [3:0] dv;
    logic [3:0] exp_cur;
    logic [3:0] exp_q[$];
    logic       armed;
    int         vectors;
    int         miscompares;

    parq_sensor_gen #(
        .PHASE_CYCLES (PH),
        .BOUNCE_PULSES(BP),
        .BOUNCE_LEN   (BL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .bounce_en(bounce_en),
        .psensor  (psensor),
        .ssensor  (ssensor),
        .busy     (busy),
        .done     (done)
    );

    assign dv = {psensor, ssensor, busy, done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Step targets per mode as {p,s} values.
    int tbl [4][4] = '{
        '{2, 3, 1, 0},
        '{1, 3, 2, 0},
        '{2, 3, 2, 0},
        '{3, 3, 3, 0}
    };

    function automatic void build(input logic [1:0] m, input logic b);
        logic [1:0] prev;
        logic [1:0] t;
        prev = 2'b00;
        for (int k = 0; k < 4; k++) begin
            t = 2'(tbl[m][k]);
            if (b && BP > 0 && t != prev) begin
                for (int i = 0; i < BP; i++) begin
                    for (int j = 0; j < BL; j++) exp_q.push_back({t, 2'b10});
                    for (int j = 0; j < BL; j++) exp_q.push_back({prev, 2'b10});
                end
            end
            for (int j = 0; j < PH; j++) exp_q.push_back({t, 2'b10});
            prev = t;
        end
        exp_q.push_back(4'b0001);
    endfunction

    // Reference model: exp_cur is what the outputs must be this cycle.
    initial begin
        exp_cur = 4'b0000;
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                exp_cur = 4'b0000;
            end else if (exp_q.size() > 0) begin
                exp_cur = exp_q.pop_front();
            end else if (start && exp_cur[1:0] == 2'b00) begin
                build(mode, bounce_en);
                exp_cur = exp_q.pop_front();
            end else begin
                exp_cur = 4'b0000;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                vectors++;
                if (dv !== exp_cur) begin
                    miscompares++;
                    $display("FAIL trace t=%0t got=%b want=%b",
                             $time, dv, exp_cur);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [3:0] got,
                       input logic [3:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%b want=%b", nm, $time, got, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic sl [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] lit;
    int ndone;

    initial begin
        armed = 1'b0;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        start = 1'b0;
        mode = 2'b00;
        bounce_en = 1'b0;
        tick();
        armed = 1'b1;
        tick();
        chk("reset_state", dv, 4'b0000);
        reset = 1'b0;
        repeat (3) tick();

        // Entry, clean edges
        mode = 2'b00;
        bounce_en = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            tick();
            start = 1'b0;
            if (c <= 3)       lit = 4'b1010;
            else if (c <= 6)  lit = 4'b1110;
            else if (c <= 9)  lit = 4'b0110;
            else if (c <= 12) lit = 4'b0010;
            else              lit = 4'b0001;
            chk("entry_dut", dv, lit);
            chk("entry_model", exp_cur, lit);
        end
        repeat (3) tick();

        // Exit with bounce
        mode = 2'b01;
        bounce_en = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            tick();
            start = 1'b0;
            bounce_en = 1'b0;
            mode = 2'b10;
            if (c <= 7) begin
                chk("exit_dut", dv, {1'b0, sl[c-1], 2'b10});
                chk("exit_model", exp_cur, {1'b0, sl[c-1], 2'b10});
            end
            if (c == 28) chk("exit_busy_end", {2'b00, busy, done}, 4'b0010);
            if (c == 29) chk("exit_done", {2'b00, busy, done}, 4'b0001);
        end
        repeat (3) tick();

        // Illegal with bounce
        mode = 2'b11;
        bounce_en = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 21; c++) begin
            tick();
            start = 1'b0;
            if (c == 1)  chk("ill_rise", dv, 4'b1110);
            if (c == 2)  chk("ill_glitch", dv, 4'b0010);
            if (c == 8)  chk("ill_step1", dv, 4'b1110);
            if (c == 13) chk("ill_step2", dv, 4'b1110);
            if (c == 14) chk("ill_fall", dv, 4'b0010);
            if (c == 15) chk("ill_fall_glitch", dv, 4'b1110);
            if (c == 18) chk("ill_settled", dv, 4'b0010);
            if (c == 21) chk("ill_done", dv, 4'b0001);
        end
        repeat (3) tick();

        // Starts during busy and on the done cycle are dropped
        mode = 2'b00;
        bounce_en = 1'b0;
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = (c == 3 || c == 10 || c == 13);
            if (done) ndone++;
            if (c == 14) chk("ign_idle", {2'b00, busy, done}, 4'b0000);
        end
        start = 1'b0;
        chk("ign_one_done", 4'(ndone), 4'd1);
        repeat (3) tick();

        // Reset mid-sequence
        start = 1'b1;
        ndone = 0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            start = (c == 8);
            reset = (c == 6);
            if (c >= 7 && c <= 20 && done) ndone++;
            if (c == 7)  chk("rst_abort", dv, 4'b0000);
            if (c == 9)  chk("rst_restart", dv, 4'b1010);
            if (c == 21) chk("rst_done", dv, 4'b0001);
        end
        start = 1'b0;
        chk("rst_no_done", 4'(ndone), 4'd0);
        repeat (3) tick();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            tick();
            reset = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 3) == 0);
            mode = 2'($urandom);
            bounce_en = 1'($urandom);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
